// File: rtl/bpsk_demodulator.sv
// bpsk_demodulator
//   Hard-decision BPSK receiver. Correlates offset-binary carrier samples against the
//   20-entry reference sine (same table as the modulator) over one symbol and emits one
//   bit per symbol.
//
// Ports
//   clk          in   rising-edge clock
//   rst          in   synchronous reset, active-high
//   enable       in   demodulator on; low aborts the current symbol and returns to idle
//   sample_in    in   offset-binary carrier sample (DATA_WIDTH)
//   sample_valid in   sample_in valid this cycle
//   sof          in   with sample_valid, marks phase index 0 of a symbol
//   bit_out      out  decided bit: 0 = in-phase (corr >= 0), 1 = inverted
//   bit_valid    out  one-cycle pulse, bit_out and corr_out are new
//   corr_out     out  signed final correlation of the last symbol (ACC_WIDTH)
//
// Build option
//   BPSK_DIFF_DECODE_EN : bit_out = hard decision XOR previous hard decision.

module bpsk_demodulator #(
    parameter int unsigned DATA_WIDTH        = 12,
    parameter int unsigned SINE_RESOLUTION   = 20,
    parameter int unsigned CYCLES_PER_SYMBOL = 1,
    parameter int unsigned MIDPOINT          = 2047,
    parameter int unsigned ACC_WIDTH         = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        enable,
    input  logic [DATA_WIDTH-1:0]       sample_in,
    input  logic                        sample_valid,
    input  logic                        sof,
    output logic                        bit_out,
    output logic                        bit_valid,
    output logic signed [ACC_WIDTH-1:0] corr_out
);

    localparam int unsigned SymLen = SINE_RESOLUTION * CYCLES_PER_SYMBOL;
    localparam int unsigned PhaseW = (SINE_RESOLUTION > 1) ? $clog2(SINE_RESOLUTION) : 1;
    localparam int unsigned CountW = (SymLen > 1) ? $clog2(SymLen) : 1;
    localparam int unsigned ProdW  = 2 * DATA_WIDTH + 2;

    localparam logic [PhaseW-1:0]          LastPhase = PhaseW'(SINE_RESOLUTION - 1);
    localparam logic [CountW-1:0]          LastCount = CountW'(SymLen - 1);
    localparam logic signed [DATA_WIDTH:0] MidS      = (DATA_WIDTH + 1)'(MIDPOINT);

    typedef enum logic [0:0] {StIdle, StAccum} state_e;

    function automatic logic [DATA_WIDTH-1:0] ref_sine(input logic [PhaseW-1:0] idx);
        logic [DATA_WIDTH-1:0] v;
        case (32'(idx))
            0:       v = DATA_WIDTH'(2047);
            1:       v = DATA_WIDTH'(2679);
            2:       v = DATA_WIDTH'(3250);
            3:       v = DATA_WIDTH'(3703);
            4:       v = DATA_WIDTH'(3993);
            5:       v = DATA_WIDTH'(4094);
            6:       v = DATA_WIDTH'(3993);
            7:       v = DATA_WIDTH'(3703);
            8:       v = DATA_WIDTH'(3250);
            9:       v = DATA_WIDTH'(2679);
            10:      v = DATA_WIDTH'(2047);
            11:      v = DATA_WIDTH'(1414);
            12:      v = DATA_WIDTH'(843);
            13:      v = DATA_WIDTH'(390);
            14:      v = DATA_WIDTH'(100);
            15:      v = DATA_WIDTH'(0);
            16:      v = DATA_WIDTH'(100);
            17:      v = DATA_WIDTH'(390);
            18:      v = DATA_WIDTH'(843);
            19:      v = DATA_WIDTH'(1414);
            default: v = DATA_WIDTH'(2047);
        endcase
        return v;
    endfunction

    state_e                      state_q, state_d;
    logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
    logic [PhaseW-1:0]           phase_q, phase_d;
    logic [CountW-1:0]           count_q, count_d;
    logic signed [ACC_WIDTH-1:0] corr_q, corr_d;
    logic                        bit_q, bit_d;
    logic                        valid_q, valid_d;
`ifdef BPSK_DIFF_DECODE_EN
    logic                        prev_q, prev_d;
    logic                        prev_base;
`endif

    logic                        start;
    logic                        accept;
    logic [PhaseW-1:0]           cur_phase;
    logic [CountW-1:0]           cur_idx;
    logic signed [DATA_WIDTH:0]  s_off, r_off;
    logic signed [ProdW-1:0]     s_ext, r_ext, prod;
    logic signed [ACC_WIDTH-1:0] prod_ext, sum;
    logic                        hard;

    // Product path for the sample being accepted this cycle.
    always_comb begin
        // sof restarts the symbol from idle, or resyncs mid-symbol; at count 0 it is a no-op.
        start     = sample_valid && sof && ((state_q == StIdle) || (count_q != '0));
        accept    = enable && sample_valid && ((state_q == StAccum) || sof);
        cur_phase = start ? '0 : phase_q;
        cur_idx   = start ? '0 : count_q;
        s_off     = $signed({1'b0, sample_in}) - MidS;
        r_off     = $signed({1'b0, ref_sine(cur_phase)}) - MidS;
        s_ext     = {{(ProdW - DATA_WIDTH - 1){s_off[DATA_WIDTH]}}, s_off};
        r_ext     = {{(ProdW - DATA_WIDTH - 1){r_off[DATA_WIDTH]}}, r_off};
        prod      = s_ext * r_ext;
        prod_ext  = {{(ACC_WIDTH - ProdW){prod[ProdW-1]}}, prod};
        // A resync discards the partial sum.
        sum       = (start ? '0 : acc_q) + prod_ext;
        hard      = sum[ACC_WIDTH-1];
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        phase_d = phase_q;
        count_d = count_q;
        corr_d  = corr_q;
        bit_d   = bit_q;
        valid_d = 1'b0;
`ifdef BPSK_DIFF_DECODE_EN
        prev_d    = prev_q;
        prev_base = start ? 1'b0 : prev_q;
`endif
        if (!enable) begin
            state_d = StIdle;
            acc_d   = '0;
            phase_d = '0;
            count_d = '0;
`ifdef BPSK_DIFF_DECODE_EN
            prev_d  = 1'b0;
`endif
        end else if (accept) begin
            state_d = StAccum;
`ifdef BPSK_DIFF_DECODE_EN
            prev_d  = prev_base;
`endif
            if (cur_idx == LastCount) begin
                corr_d  = sum;
                valid_d = 1'b1;
                acc_d   = '0;
                phase_d = '0;
                count_d = '0;
`ifdef BPSK_DIFF_DECODE_EN
                bit_d   = hard ^ prev_base;
                prev_d  = hard;
`else
                bit_d   = hard;
`endif
            end else begin
                acc_d   = sum;
                phase_d = (cur_phase == LastPhase) ? '0 : cur_phase + PhaseW'(1);
                count_d = cur_idx + CountW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            acc_q   <= '0;
            phase_q <= '0;
            count_q <= '0;
            corr_q  <= '0;
            bit_q   <= 1'b0;
            valid_q <= 1'b0;
`ifdef BPSK_DIFF_DECODE_EN
            prev_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            phase_q <= phase_d;
            count_q <= count_d;
            corr_q  <= corr_d;
            bit_q   <= bit_d;
            valid_q <= valid_d;
`ifdef BPSK_DIFF_DECODE_EN
            prev_q  <= prev_d;
`endif
        end
    end

    assign bit_out   = bit_q;
    assign bit_valid = valid_q;
    assign corr_out  = corr_q;

endmodule

// File: tb/tb_bpsk_demodulator.sv
// Directed self-checking bench for bpsk_demodulator (default parameters).
module tb_bpsk_demodulator;

    logic               clk = 1'b0;
    logic               rst;
    logic               enable;
    logic [11:0]        sample_in;
    logic               sample_valid;
    logic               sof;
    logic               bit_out;
    logic               bit_valid;
    logic signed [31:0] corr_out;

    localparam logic signed [31:0] CorrIn  = 32'sd41905714;
    localparam logic signed [31:0] CorrInv = -32'sd41905714;

    int tbl[20] = '{2047, 2679, 3250, 3703, 3993, 4094, 3993, 3703, 3250, 2679,
                    2047, 1414, 843, 390, 100, 0, 100, 390, 843, 1414};

    int   checks = 0;
    int   errors = 0;
    int   pulses = 0;
    int   cyc    = 0;
    logic bits_q[$];
    int   pcyc_q[$];

    bpsk_demodulator dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .sof          (sof),
        .bit_out      (bit_out),
        .bit_valid    (bit_valid),
        .corr_out     (corr_out)
    );

    always #5 clk = ~clk;

    // One clock with the given inputs; records any bit_valid pulse produced by that edge.
    task automatic send(input int s, input logic v, input logic f);
        sample_in    = 12'(s);
        sample_valid = v;
        sof          = f;
        @(posedge clk);
        #1;
        cyc++;
        if (bit_valid) begin
            pulses++;
            bits_q.push_back(bit_out);
            pcyc_q.push_back(cyc);
        end
        sample_valid = 1'b0;
        sof          = 1'b0;
    endtask

    function automatic int carrier(input int i, input logic inv);
        return inv ? (4094 - tbl[i % 20]) : tbl[i % 20];
    endfunction

    task automatic clear_log();
        pulses = 0;
        bits_q.delete();
        pcyc_q.delete();
    endtask

    task automatic abort_cycle();
        enable = 1'b0;
        send(0, 1'b0, 1'b0);
        enable = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        enable = 1'b0;
        send(0, 1'b0, 1'b0);
        send(0, 1'b0, 1'b0);
        rst = 1'b0;
        checks++;
        if (bit_out !== 1'b0) begin
            errors++;
            $display("FAIL reset_bit_out: got %b want 0", bit_out);
        end
        checks++;
        if (bit_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_bit_valid: got %b want 0", bit_valid);
        end
        checks++;
        if (corr_out !== 32'sd0) begin
            errors++;
            $display("FAIL reset_corr_out: got %0d want 0", corr_out);
        end
    endtask

    task automatic test_in_phase();
        enable = 1'b1;
        clear_log();
        for (int i = 0; i < 19; i++) send(carrier(i, 1'b0), 1'b1, i == 0);
        checks++;
        if (pulses !== 0) begin
            errors++;
            $display("FAIL inphase_early_pulse: got %0d want 0", pulses);
        end
        send(carrier(19, 1'b0), 1'b1, 1'b0);
        checks++;
        if (bit_valid !== 1'b1) begin
            errors++;
            $display("FAIL inphase_bit_valid: got %b want 1", bit_valid);
        end
        checks++;
        if (bit_out !== 1'b0) begin
            errors++;
            $display("FAIL inphase_bit_out: got %b want 0", bit_out);
        end
        checks++;
        if (corr_out !== CorrIn) begin
            errors++;
            $display("FAIL inphase_corr: got %0d want %0d", corr_out, CorrIn);
        end
        send(0, 1'b0, 1'b0);
        checks++;
        if (bit_valid !== 1'b0) begin
            errors++;
            $display("FAIL inphase_pulse_width: got %b want 0", bit_valid);
        end
    endtask

    task automatic test_inverted();
        clear_log();
        for (int i = 0; i < 20; i++) send(carrier(i, 1'b1), 1'b1, i == 0);
        checks++;
        if (pulses !== 1) begin
            errors++;
            $display("FAIL inverted_pulses: got %0d want 1", pulses);
        end
        checks++;
        if (bit_out !== 1'b1) begin
            errors++;
            $display("FAIL inverted_bit_out: got %b want 1", bit_out);
        end
        checks++;
        if (corr_out !== CorrInv) begin
            errors++;
            $display("FAIL inverted_corr: got %0d want %0d", corr_out, CorrInv);
        end
    endtask

    task automatic test_back_to_back();
        logic       inv_pat[4] = '{1'b0, 1'b1, 1'b1, 1'b0};
        logic [3:0] got;
        logic [3:0] want;
`ifdef BPSK_DIFF_DECODE_EN
        want = 4'b0101;
`else
        want = 4'b0110;
`endif
        abort_cycle();
        clear_log();
        for (int s = 0; s < 4; s++)
            for (int i = 0; i < 20; i++) send(carrier(i, inv_pat[s]), 1'b1, s == 0 && i == 0);
        checks++;
        if (pulses !== 4) begin
            errors++;
            $display("FAIL b2b_pulses: got %0d want 4", pulses);
        end
        got = 4'b0;
        for (int k = 0; k < 4 && k < bits_q.size(); k++) got[3-k] = bits_q[k];
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL b2b_bits: got %b want %b", got, want);
        end
        for (int k = 0; k + 1 < pcyc_q.size(); k++) begin
            checks++;
            if (pcyc_q[k+1] - pcyc_q[k] !== 20) begin
                errors++;
                $display("FAIL b2b_spacing%0d: got %0d want 20", k, pcyc_q[k+1] - pcyc_q[k]);
            end
        end
    endtask

    task automatic test_gaps();
        int gap_after[20] = '{0, 1, 0, 2, 0, 0, 1, 0, 3, 0, 0, 0, 1, 0, 0, 2, 0, 0, 1, 0};
        abort_cycle();
        clear_log();
        for (int i = 0; i < 20; i++) begin
            send(carrier(i, 1'b1), 1'b1, i == 0);
            if (i == 18) begin
                checks++;
                if (pulses !== 0) begin
                    errors++;
                    $display("FAIL gaps_early_pulse: got %0d want 0", pulses);
                end
            end
            if (i < 19) for (int g = 0; g < gap_after[i]; g++) send(0, 1'b0, 1'b0);
        end
        checks++;
        if (pulses !== 1 || bit_valid !== 1'b1) begin
            errors++;
            $display("FAIL gaps_pulse: got %0d/%b want 1/1", pulses, bit_valid);
        end
        checks++;
        if (bit_out !== 1'b1) begin
            errors++;
            $display("FAIL gaps_bit_out: got %b want 1", bit_out);
        end
        checks++;
        if (corr_out !== CorrInv) begin
            errors++;
            $display("FAIL gaps_corr: got %0d want %0d", corr_out, CorrInv);
        end
    endtask

    task automatic test_resync();
        abort_cycle();
        clear_log();
        for (int i = 0; i < 7; i++) send(carrier(i, 1'b1), 1'b1, i == 0);
        for (int i = 0; i < 20; i++) send(carrier(i, 1'b0), 1'b1, i == 0);
        checks++;
        if (pulses !== 1) begin
            errors++;
            $display("FAIL resync_pulses: got %0d want 1", pulses);
        end
        checks++;
        if (corr_out !== CorrIn) begin
            errors++;
            $display("FAIL resync_corr: got %0d want %0d", corr_out, CorrIn);
        end
        checks++;
        if (bit_out !== 1'b0) begin
            errors++;
            $display("FAIL resync_bit_out: got %b want 0", bit_out);
        end
    endtask

    task automatic test_abort();
        clear_log();
        for (int i = 0; i < 10; i++) send(carrier(i, 1'b1), 1'b1, i == 0);
        enable = 1'b0;
        send(carrier(10, 1'b1), 1'b1, 1'b0);
        enable = 1'b1;
        // Idle must ignore everything without sof.
        for (int i = 11; i < 36; i++) send(carrier(i, 1'b1), 1'b1, 1'b0);
        checks++;
        if (pulses !== 0) begin
            errors++;
            $display("FAIL abort_pulses: got %0d want 0", pulses);
        end
        checks++;
        if (corr_out !== CorrIn) begin
            errors++;
            $display("FAIL abort_corr_hold: got %0d want %0d", corr_out, CorrIn);
        end
        checks++;
        if (bit_out !== 1'b0) begin
            errors++;
            $display("FAIL abort_bit_hold: got %b want 0", bit_out);
        end
        for (int i = 0; i < 20; i++) send(carrier(i, 1'b1), 1'b1, i == 0);
        checks++;
        if (pulses !== 1) begin
            errors++;
            $display("FAIL abort_restart_pulses: got %0d want 1", pulses);
        end
        checks++;
        if (corr_out !== CorrInv || bit_out !== 1'b1) begin
            errors++;
            $display("FAIL abort_restart: got %0d/%b want %0d/1", corr_out, bit_out, CorrInv);
        end
    endtask

    task automatic test_mid_reset();
        clear_log();
        for (int i = 0; i < 12; i++) send(carrier(i, 1'b0), 1'b1, i == 0);
        rst = 1'b1;
        send(carrier(12, 1'b0), 1'b1, 1'b0);
        rst = 1'b0;
        checks++;
        if (bit_out !== 1'b0 || bit_valid !== 1'b0 || corr_out !== 32'sd0) begin
            errors++;
            $display("FAIL midrst_outputs: got %b/%b/%0d want 0/0/0", bit_out, bit_valid, corr_out);
        end
        checks++;
        if (pulses !== 0) begin
            errors++;
            $display("FAIL midrst_pulses: got %0d want 0", pulses);
        end
        for (int i = 13; i < 20; i++) send(carrier(i, 1'b0), 1'b1, 1'b0);
        checks++;
        if (pulses !== 0) begin
            errors++;
            $display("FAIL midrst_idle: got %0d want 0", pulses);
        end
        for (int i = 0; i < 20; i++) send(carrier(i, 1'b1), 1'b1, i == 0);
        checks++;
        if (pulses !== 1) begin
            errors++;
            $display("FAIL midrst_after_pulses: got %0d want 1", pulses);
        end
        checks++;
        if (corr_out !== CorrInv || bit_out !== 1'b1) begin
            errors++;
            $display("FAIL midrst_after: got %0d/%b want %0d/1", corr_out, bit_out, CorrInv);
        end
    endtask

    initial begin
        rst          = 1'b1;
        enable       = 1'b0;
        sample_in    = '0;
        sample_valid = 1'b0;
        sof          = 1'b0;
        test_reset();
        test_in_phase();
        test_inverted();
        test_back_to_back();
        test_gaps();
        test_resync();
        test_abort();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
